// File: rtl/link_rx_symbol_framer.sv
`default_nettype none
// ============================================================================
// Module      : link_rx_symbol_framer
// Description : Receive-side 4B/5B symbol framer for the EoverP link (pair 36).
//               Hunts for the J/K start-of-stream delimiter in the recovered
//               serial stream, locks 5-bit symbol alignment, decodes data code
//               groups to nibbles and queues them in a small FIFO with a
//               valid/ready interface toward the MAC side.
// Ports       : Clock100MhzP - 100 MHz link clock (rising edge)
//               ResetN       - asynchronous active-low reset
//               SerialIn     - recovered line bit, first bit of a group first
//               RxReady      - consumer accepts head entry on RxValid&&RxReady
//               RxValid      - FIFO non-empty
//               RxNibble     - head entry data
//               RxSof        - head entry is first data nibble of a frame
//               RxEof        - head entry is an end-of-frame marker
//               RxErr        - Eof marker belongs to an aborted frame
//               Locked       - framer is aligned (DATA or ESD_R)
//               CodeError    - one-cycle pulse on an abort
//               Overflow     - sticky, a push was dropped on a full FIFO
//               FrameCount / ErrorCount - saturating frame statistics, present
//               only when LINK_RX_SYMBOL_FRAMER_STATS_EN is defined
// Parameters  : FIFO_DEPTH   - nibble FIFO entries, power of 2, 4..64
// Revision    : 1.0 - initial release
// ============================================================================
module link_rx_symbol_framer #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        Clock100MhzP,
   input  logic        ResetN,
   input  logic        SerialIn,
   input  logic        RxReady,
   output logic        RxValid,
   output logic [3:0]  RxNibble,
   output logic        RxSof,
   output logic        RxEof,
   output logic        RxErr,
   output logic        Locked,
   output logic        CodeError,
`ifdef LINK_RX_SYMBOL_FRAMER_STATS_EN
   output logic [15:0] FrameCount,
   output logic [15:0] ErrorCount,
`endif
   output logic        Overflow
);

   localparam int         AW     = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(FIFO_DEPTH);

   localparam logic [1:0] S_HUNT = 2'd0;
   localparam logic [1:0] S_SSDK = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_ESDR = 2'd3;

   localparam logic [4:0] C_J = 5'b11000;
   localparam logic [4:0] C_K = 5'b10001;
   localparam logic [4:0] C_T = 5'b01101;
   localparam logic [4:0] C_R = 5'b00111;

   // Only the last four bits need storing: the fifth bit of the shift
   // register would fall out on the very edge that examines it.
   logic [3:0] r_hist;
   logic [2:0] r_cnt;
   logic [1:0] r_state;
   logic       r_sof_arm;
   logic       r_push_vld;
   logic [6:0] r_push_data;   // {Err, Eof, Sof, nibble}
   logic       r_code_err;

   logic [4:0] w_sh_next;
   logic       w_grp_done;
   logic       w_dec_ok;
   logic [3:0] w_dec_nib;
   logic       w_abort;
   logic       w_good_eof;

   assign w_sh_next  = {r_hist, SerialIn};
   assign w_grp_done = (r_state != S_HUNT) && (r_cnt == 3'd4);

   always_comb begin
      w_dec_ok  = 1'b1;
      w_dec_nib = 4'h0;
      case (w_sh_next)
         5'b11110: w_dec_nib = 4'h0;
         5'b01001: w_dec_nib = 4'h1;
         5'b10100: w_dec_nib = 4'h2;
         5'b10101: w_dec_nib = 4'h3;
         5'b01010: w_dec_nib = 4'h4;
         5'b01011: w_dec_nib = 4'h5;
         5'b01110: w_dec_nib = 4'h6;
         5'b01111: w_dec_nib = 4'h7;
         5'b10010: w_dec_nib = 4'h8;
         5'b10011: w_dec_nib = 4'h9;
         5'b10110: w_dec_nib = 4'hA;
         5'b10111: w_dec_nib = 4'hB;
         5'b11010: w_dec_nib = 4'hC;
         5'b11011: w_dec_nib = 4'hD;
         5'b11100: w_dec_nib = 4'hE;
         5'b11101: w_dec_nib = 4'hF;
         default:  w_dec_ok  = 1'b0;
      endcase
   end

   assign w_good_eof = w_grp_done && (r_state == S_ESDR) && (w_sh_next == C_R);
   assign w_abort    = w_grp_done &&
                       (((r_state == S_DATA) && !w_dec_ok && (w_sh_next != C_T)) ||
                        ((r_state == S_ESDR) && (w_sh_next != C_R)));

   // Decoded entries are staged one cycle before the FIFO write.
   always_ff @(posedge Clock100MhzP or negedge ResetN) begin
      if (!ResetN) begin
         r_hist      <= 4'd0;
         r_cnt       <= 3'd0;
         r_state     <= S_HUNT;
         r_sof_arm   <= 1'b0;
         r_push_vld  <= 1'b0;
         r_push_data <= 7'd0;
         r_code_err  <= 1'b0;
      end else begin
         r_hist     <= w_sh_next[3:0];
         r_push_vld <= 1'b0;
         r_code_err <= 1'b0;
         if (r_state == S_HUNT) begin
            if (w_sh_next == C_J) begin
               r_state <= S_SSDK;
               r_cnt   <= 3'd0;
            end
         end else begin
            r_cnt <= (r_cnt == 3'd4) ? 3'd0 : r_cnt + 3'd1;
            if (w_abort) begin
               r_code_err  <= 1'b1;
               r_push_vld  <= 1'b1;
               r_push_data <= 7'b110_0000;
               r_sof_arm   <= 1'b0;
               r_state     <= S_HUNT;
            end else if (w_good_eof) begin
               r_push_vld  <= 1'b1;
               r_push_data <= 7'b010_0000;
               r_sof_arm   <= 1'b0;
               r_state     <= S_HUNT;
            end else if (w_grp_done) begin
               case (r_state)
                  S_SSDK: begin
                     if (w_sh_next == C_K) begin
                        r_state   <= S_DATA;
                        r_sof_arm <= 1'b1;
                     end else begin
                        r_state <= S_HUNT;
                     end
                  end
                  S_DATA: begin
                     if (w_dec_ok) begin
                        r_push_vld  <= 1'b1;
                        r_push_data <= {2'b00, r_sof_arm, w_dec_nib};
                        r_sof_arm   <= 1'b0;
                     end else begin
                        r_state <= S_ESDR;   // only T reaches here
                     end
                  end
                  default: r_state <= S_HUNT;
               endcase
            end
         end
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [6:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;

   logic       w_full;
   logic       w_pop;
   logic       w_push;
   logic [6:0] w_head;

   assign w_full  = (r_count == C_FULL);
   assign w_pop   = (r_count != '0) && RxReady;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_push  = r_push_vld && (!w_full || w_pop);
   assign w_head  = r_mem[r_rd_ptr];

   always_ff @(posedge Clock100MhzP) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_push_data;
      end
   end

   always_ff @(posedge Clock100MhzP or negedge ResetN) begin
      if (!ResetN) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (r_push_vld && !w_push) r_overflow <= 1'b1;
      end
   end

`ifdef LINK_RX_SYMBOL_FRAMER_STATS_EN
   logic [15:0] r_frame_cnt;
   logic [15:0] r_error_cnt;

   always_ff @(posedge Clock100MhzP or negedge ResetN) begin
      if (!ResetN) begin
         r_frame_cnt <= 16'd0;
         r_error_cnt <= 16'd0;
      end else begin
         if (w_good_eof && (r_frame_cnt != 16'hFFFF)) r_frame_cnt <= r_frame_cnt + 16'd1;
         if (w_abort && (r_error_cnt != 16'hFFFF))    r_error_cnt <= r_error_cnt + 16'd1;
      end
   end

   assign FrameCount = r_frame_cnt;
   assign ErrorCount = r_error_cnt;
`endif

   // Head fields are masked while empty so the memory needs no reset.
   assign RxValid   = (r_count != '0);
   assign RxNibble  = RxValid ? w_head[3:0] : 4'h0;
   assign RxSof     = RxValid & w_head[4];
   assign RxEof     = RxValid & w_head[5];
   assign RxErr     = RxValid & w_head[6];
   assign Locked    = (r_state == S_DATA) || (r_state == S_ESDR);
   assign CodeError = r_code_err;
   assign Overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_link_rx_symbol_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_rx_symbol_framer
// Description : Scoreboard bench for link_rx_symbol_framer. Directed 4B/5B
//               bit streams are driven; expected FIFO entries are queued as
//               the stimulus is issued and an independent monitor pops and
//               compares them whenever the DUT hands over an entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_rx_symbol_framer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ser = 1'b1;
   logic        rdy = 1'b0;
   logic        RxValid, RxSof, RxEof, RxErr, Locked, CodeError, Overflow;
   logic [3:0]  RxNibble;
`ifdef LINK_RX_SYMBOL_FRAMER_STATS_EN
   logic [15:0] FrameCount, ErrorCount;
`endif

   link_rx_symbol_framer #(.FIFO_DEPTH(8)) dut (
      .Clock100MhzP (clk),
      .ResetN       (rst_n),
      .SerialIn     (ser),
      .RxReady      (rdy),
      .RxValid      (RxValid),
      .RxNibble     (RxNibble),
      .RxSof        (RxSof),
      .RxEof        (RxEof),
      .RxErr        (RxErr),
      .Locked       (Locked),
      .CodeError    (CodeError),
`ifdef LINK_RX_SYMBOL_FRAMER_STATS_EN
      .FrameCount   (FrameCount),
      .ErrorCount   (ErrorCount),
`endif
      .Overflow     (Overflow)
   );

   always #5 clk = ~clk;

   localparam logic [4:0] J = 5'b11000, K = 5'b10001, T = 5'b01101, R = 5'b00111;
   logic [4:0] nib_code [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                                 5'b01010, 5'b01011, 5'b01110, 5'b01111,
                                 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                 5'b11010, 5'b11011, 5'b11100, 5'b11101};

   int         n_checks = 0;
   int         n_pass   = 0;
   int         ce_cnt   = 0;
   logic [6:0] exp_q [$];      // {Err, Eof, Sof, nibble}

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Monitor: mid-cycle sample; a handshake seen here completes on the next edge.
   always @(negedge clk) begin
      if (CodeError) ce_cnt++;
      if (rst_n && RxValid && rdy) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_entry: got %0h expected none",
                     {RxErr, RxEof, RxSof, RxNibble});
         end else begin
            chk("entry", {25'd0, RxErr, RxEof, RxSof, RxNibble}, {25'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   // Drive one bit (and RxReady) for one cycle; returns 1 unit after the sampling edge.
   task automatic send_bit(input logic b, input logic r);
      ser = b;
      rdy = r;
      @(posedge clk);
      #1;
   endtask

   task automatic send_sym(input logic [4:0] c, input logic r0, input logic r);
      for (int i = 0; i < 5; i++) send_bit(c[4-i], (i == 0) ? r0 : r);
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) send_bit(1'b1, r);
   endtask

   task automatic send_nib(input int n, input logic r0, input logic r,
                           input logic sof, input logic expect_push);
      if (expect_push) exp_q.push_back({2'b00, sof, 4'(n)});
      send_sym(nib_code[n], r0, r);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int ce0;

   initial begin
      // ---- reset values
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {21'd0, RxValid, RxNibble, RxSof, RxEof, RxErr, Locked,
                            CodeError, Overflow}, 32'd0);
      rst_n = 1'b1;

      // ---- basic frame J K 5 A T R with RxReady high
      idle(40, 1'b1);
      send_sym(J, 1'b1, 1'b1);
      chk("locked_after_J", {31'd0, Locked}, 32'd0);
      for (int i = 0; i < 4; i++) send_bit(K[4-i], 1'b1);
      chk("locked_before_K_end", {31'd0, Locked}, 32'd0);
      send_bit(K[0], 1'b1);
      chk("locked_after_K", {31'd0, Locked}, 32'd1);
      send_nib(5, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("no_bypass", {31'd0, RxValid}, 32'd0);
      send_nib(10, 1'b1, 1'b1, 1'b0, 1'b1);
      send_sym(T, 1'b1, 1'b1);
      chk("locked_in_esd", {31'd0, Locked}, 32'd1);
      exp_q.push_back(7'b010_0000);
      send_sym(R, 1'b1, 1'b1);
      chk("unlock_after_R", {31'd0, Locked}, 32'd0);
      idle(10, 1'b1);
      chk("frame1_drained", exp_q.size(), 32'd0);

      // ---- abort: IDLE in data position
      ce0 = ce_cnt;
      send_sym(J, 1'b1, 1'b1);
      send_sym(K, 1'b1, 1'b1);
      exp_q.push_back(7'b110_0000);
      send_sym(5'b11111, 1'b1, 1'b1);
      chk("abort_unlock", {31'd0, Locked}, 32'd0);
      idle(10, 1'b1);
      chk("abort_codeerr_pulses", ce_cnt - ce0, 32'd1);
      chk("abort_drained", exp_q.size(), 32'd0);

      // ---- J followed by non-K: silent return to hunt, then a good frame
      ce0 = ce_cnt;
      send_sym(J, 1'b1, 1'b1);
      send_sym(5'b10101, 1'b1, 1'b1);
      idle(10, 1'b1);
      chk("badk_no_codeerr", ce_cnt - ce0, 32'd0);
      chk("badk_unlocked", {31'd0, Locked}, 32'd0);
      send_sym(J, 1'b1, 1'b1);
      send_sym(K, 1'b1, 1'b1);
      send_nib(7, 1'b1, 1'b1, 1'b1, 1'b1);
      send_sym(T, 1'b1, 1'b1);
      exp_q.push_back(7'b010_0000);
      send_sym(R, 1'b1, 1'b1);
      idle(10, 1'b1);
      chk("badk_next_frame", exp_q.size(), 32'd0);

      // ---- overflow: 12 nibbles into an 8-deep FIFO with RxReady low
      send_sym(J, 1'b0, 1'b0);
      send_sym(K, 1'b0, 1'b0);
      for (int d = 0; d < 12; d++) send_nib(d, 1'b0, 1'b0, d == 0, d < 8);
      send_sym(T, 1'b0, 1'b0);
      send_sym(R, 1'b0, 1'b0);
      idle(10, 1'b0);
      chk("ovf_set", {31'd0, Overflow}, 32'd1);
      chk("ovf_full_valid", {31'd0, RxValid}, 32'd1);
      idle(15, 1'b1);
      chk("ovf_drained", exp_q.size(), 32'd0);
      chk("ovf_empty", {31'd0, RxValid}, 32'd0);
      chk("ovf_sticky", {31'd0, Overflow}, 32'd1);

      // ---- reset asserted mid-DATA
      send_sym(J, 1'b0, 1'b0);
      send_sym(K, 1'b0, 1'b0);
      send_nib(1, 1'b0, 1'b0, 1'b1, 1'b1);
      send_nib(2, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) send_bit(nib_code[3][4-i], 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", {21'd0, RxValid, RxNibble, RxSof, RxEof, RxErr, Locked,
                               CodeError, Overflow}, 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(10, 1'b1);
      chk("midreset_no_entries", {31'd0, RxValid}, 32'd0);
      send_sym(J, 1'b1, 1'b1);
      send_sym(K, 1'b1, 1'b1);
      send_nib(3, 1'b1, 1'b1, 1'b1, 1'b1);
      send_sym(T, 1'b1, 1'b1);
      exp_q.push_back(7'b010_0000);
      send_sym(R, 1'b1, 1'b1);
      idle(10, 1'b1);
      chk("midreset_frame", exp_q.size(), 32'd0);

      // ---- full FIFO: pops only on the cycles where a write lands
      send_sym(J, 1'b0, 1'b0);
      send_sym(K, 1'b0, 1'b0);
      for (int d = 0; d < 12; d++) send_nib(d, d >= 9, 1'b0, d == 0, 1'b1);
      send_sym(T, 1'b1, 1'b0);
      exp_q.push_back(7'b010_0000);
      send_sym(R, 1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      chk("fullpop_still_full", {31'd0, RxValid}, 32'd1);
      chk("fullpop_no_ovf", {31'd0, Overflow}, 32'd0);
      idle(15, 1'b1);
      chk("fullpop_drained", exp_q.size(), 32'd0);
      chk("fullpop_no_ovf_end", {31'd0, Overflow}, 32'd0);

      // ---- two good frames (one with no data) and one abort
      do_reset();
      idle(10, 1'b1);
      ce0 = ce_cnt;
      send_sym(J, 1'b1, 1'b1);
      send_sym(K, 1'b1, 1'b1);
      send_nib(15, 1'b1, 1'b1, 1'b1, 1'b1);
      send_sym(T, 1'b1, 1'b1);
      exp_q.push_back(7'b010_0000);
      send_sym(R, 1'b1, 1'b1);
      idle(5, 1'b1);
      send_sym(J, 1'b1, 1'b1);
      send_sym(K, 1'b1, 1'b1);
      send_sym(T, 1'b1, 1'b1);
      exp_q.push_back(7'b010_0000);
      send_sym(R, 1'b1, 1'b1);
      idle(5, 1'b1);
      send_sym(J, 1'b1, 1'b1);
      send_sym(K, 1'b1, 1'b1);
      exp_q.push_back(7'b110_0000);
      send_sym(K, 1'b1, 1'b1);
      idle(10, 1'b1);
      chk("stats_frames_drained", exp_q.size(), 32'd0);
      chk("stats_codeerr", ce_cnt - ce0, 32'd1);
`ifdef LINK_RX_SYMBOL_FRAMER_STATS_EN
      chk("frame_count", {16'd0, FrameCount}, 32'd2);
      chk("error_count", {16'd0, ErrorCount}, 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
